// File: rtl/uart_frame_loader_if.sv
// Byte-stream input and operand-buffer write bus of the UART frame loader.
// The master side is the loader itself; the slave side is the environment
// that supplies received bytes and sinks element writes and frame status.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 2
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    input  in_data, in_valid,
    output wr_en, wr_sel, wr_addr, wr_data, busy, frame_done, frame_err
  );

  modport slave (
    output in_data, in_valid,
    input  wr_en, wr_sel, wr_addr, wr_data, busy, frame_done, frame_err
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses a framed matrix upload (sync, N*N bytes of A, N*N bytes of B,
// checksum) from the UART byte stream and issues row-major element writes
// into the A/B operand buffers, reporting frame completion or error.
//
// state  | meaning
// IDLE   | waiting for the sync byte, other bytes ignored
// LOAD_A | each byte is written to buffer A at the element counter
// LOAD_B | each byte is written to buffer B at the element counter
// CHECK  | next byte is compared against the running payload sum
module uart_frame_loader #(
  parameter int          N         = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 100000,
  parameter int          ADDR_W    = (N * N > 1) ? $clog2(N * N) : 1
) (
  input logic                 clk,
  input logic                 rst,
  uart_frame_loader_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N * N - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              last_elem;
  logic              tmo_expire;

  assign in_valid   = bus.in_valid;
  assign in_data    = bus.in_data;
  assign last_elem  = (cnt_q == LAST_ELEM);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_expire = !in_valid && (tmo_q == TMO_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode: sync starts a frame, element count advances A->B->CHECK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_data == SYNC_BYTE) state_d = LOAD_A;
      end
      LOAD_A: begin
        if (in_valid && last_elem) state_d = LOAD_B;
        else if (tmo_expire)       state_d = IDLE;
      end
      LOAD_B: begin
        if (in_valid && last_elem) state_d = CHECK;
        else if (tmo_expire)       state_d = IDLE;
      end
      CHECK: begin
        if (in_valid || tmo_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath decode: element writes, checksum, timeout and status pulses.
  always_comb begin
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    tmo_d     = '0;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_data == SYNC_BYTE) begin
          cnt_d = '0;
          sum_d = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = (state_q == LOAD_B);
          wr_addr_d = cnt_q;
          wr_data_d = in_data;
          sum_d     = sum_q + in_data;
          cnt_d     = last_elem ? '0 : cnt_q + ADDR_W'(1);
        end else if (tmo_expire) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CHECK: begin
        if (in_valid) begin
          if (in_data == sum_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end else if (tmo_expire) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Consumes the received-byte stream (8-bit data plus a one-cycle valid strobe) from the UART receiver.
- Parses a framed matrix upload: sync byte, N*N bytes of matrix A, N*N bytes of matrix B, then a checksum byte.
- Issues row-major element writes into the A/B operand buffers of the matrix-multiply core.
- Signals frame completion, or frame error, to the control sequencer.

Parameters:
- N, 2, matrix dimension; each matrix holds N*N 8-bit elements.
- SYNC_BYTE, 8'hA5, byte value that starts a frame.
- TIMEOUT, 100000, maximum idle clock cycles allowed between bytes inside a frame before the frame is aborted.
- ADDR_W, clog2(N*N) with a minimum of 1, width of the element address.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset; low at a rising clk edge resets the block.
- in_data  input  8  received byte.
- in_valid  input  1  one-cycle strobe; in_data is valid in that cycle.
- wr_en  output  1  element write strobe, one cycle.
- wr_sel  output  1  target buffer: 0 = A, 1 = B.
- wr_addr  output  ADDR_W  row-major element index (row*N + col).
- wr_data  output  8  element value.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse: frame complete and checksum matched.
- frame_err  output  1  one-cycle pulse: checksum mismatch or inter-byte timeout.

Behaviour:
- Reset (rst low at a clk edge):
  - State becomes IDLE.
  - wr_en, wr_sel, wr_addr, wr_data, busy, frame_done, frame_err all become 0.
  - Element counter, checksum accumulator and timeout counter are cleared.
  - Reset applied mid-frame discards the partial frame and produces no pulse.
- States: IDLE, LOAD_A, LOAD_B, CHECK.
  - IDLE: in_valid with in_data == SYNC_BYTE -> LOAD_A; element counter = 0, checksum = 0. Any other byte is ignored.
  - LOAD_A: each in_valid writes one element with wr_sel = 0, wr_addr = element counter, wr_data = in_data. The counter increments; after element N*N-1 the counter wraps to 0 -> LOAD_B.
  - LOAD_B: same as LOAD_A with wr_sel = 1; after element N*N-1 -> CHECK.
  - CHECK: the next in_valid is the checksum byte.
    - If in_data equals the accumulator: frame_done pulses.
    - Otherwise: frame_err pulses.
    - Either way -> IDLE. No write is issued for the checksum byte.
- Sync byte value inside the payload is ordinary data; there is no resync mid-frame.
- Checksum: 8-bit sum modulo 256 of all 2*N*N payload bytes. The sync byte and the checksum byte are excluded.
- Timing:
  - Writes are registered: wr_en/wr_sel/wr_addr/wr_data are asserted in the cycle after the accepting in_valid edge, for exactly one cycle.
  - wr_sel/wr_addr/wr_data hold their last values while wr_en is low.
  - frame_done/frame_err assert in the cycle after the checksum byte is accepted, for one cycle.
  - frame_done and frame_err are never high together.
- Timeout:
  - Counter counts cycles without in_valid while in LOAD_A, LOAD_B or CHECK.
  - Counter reaching TIMEOUT -> frame_err pulse, -> IDLE.
  - in_valid in the same cycle the count would expire takes priority: the byte is accepted and the counter is cleared.
  - The counter is held at 0 in IDLE.
- busy is a registered output: high from the cycle after the sync byte is accepted until the cycle in which frame_done/frame_err is high; low thereafter.
- Back-to-back in_valid on consecutive cycles must be accepted with no loss. The block never stalls and has no backpressure.
- A new sync byte may be accepted on the cycle immediately after the return to IDLE.

Test Plan:
1. N=2, bytes A5, 01 02 03 04, 05 06 07 08, 24 -> 8 writes:
   - A[0..3] = 01..04, then B[0..3] = 05..08.
   - frame_done pulses once; frame_err stays 0; busy returns to 0.
2. Same frame with checksum byte 25 -> 8 writes still issued; frame_err pulses once; frame_done stays 0.
3. Bytes 00 FF 3C, then a valid frame -> the first three bytes produce no writes and no pulses; the frame loads correctly with frame_done.
4. TIMEOUT=50: A5 01 02, then 50 idle cycles -> frame_err pulses once and busy drops. A following valid frame completes with frame_done and addresses restarting at A[0].
5. rst driven low for one cycle after the fifth payload byte -> all outputs 0, no pulse. A subsequent full valid frame completes normally.
6. Frame bytes on consecutive cycles (in_valid held high for 10 cycles) with payload A5 repeated as data, checksum 0x28 -> all 8 writes occur on consecutive cycles with data A5, and frame_done pulses.
